// File: rtl/instr_fetch.sv
// Fetch stage: owns the program counter, issues one instruction-memory request
// at a time and hands the returned word to decode, applying taken branches.
module instr_fetch #(
  parameter int              xlen     = 64,
  parameter logic [xlen-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [xlen-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [xlen-1:0] pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [xlen-1:0] imm_branch,
  output logic            fetch_misalign
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [xlen-1:0] pc_nxt;
  logic [31:0]     instr_nxt;
  logic            instr_valid_nxt;
  logic            misalign_nxt;
  logic [xlen-1:0] branch_tgt;
  logic            accept;

  // The request is a pure function of the state; it is held low while reset
  // is asserted so nothing is issued before the first post-reset cycle.
  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_addr      = pc;
  assign accept         = instr_valid && instr_ready;
  assign branch_tgt     = pc + imm_branch;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the case statement leaves a value unassigned (no latches).
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_valid_nxt = instr_valid;
    misalign_nxt    = fetch_misalign;

    unique case (state)
      REQ: begin
        if (imem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_nxt       = imem_rdata;
          instr_valid_nxt = 1'b1;
          state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          instr_valid_nxt = 1'b0;
          if (!branch_taken) begin
            pc_nxt    = pc + xlen'(4);
            state_nxt = REQ;
          end else if (branch_tgt[1]) begin
            // Target is only half-word aligned: stop fetching, keep pc.
            misalign_nxt = 1'b1;
            state_nxt    = FAULT;
          end else begin
            pc_nxt    = branch_tgt;
            state_nxt = REQ;
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = REQ;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= REQ;
      pc             <= RESET_PC;
      instr          <= '0;
      instr_valid    <= 1'b0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      instr          <= instr_nxt;
      instr_valid    <= instr_valid_nxt;
      fetch_misalign <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: a memory agent, a decode driver with a
// fetch-order reference model, and a negedge monitor draining expected queues.
module tb_instr_fetch;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RST_PC   = 64'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [63:0] imm_branch;
  logic        fetch_misalign;

  instr_fetch #(.xlen(XLEN), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .pc             (pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .branch_taken   (branch_taken),
    .imm_branch     (imm_branch),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] word;
  } exp_instr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_addr[$];
  exp_instr_t  exp_instr[$];
  logic [63:0] m_pc;
  bit          m_fault;

  // memory agent configuration
  int          ready_pct    = 100;
  int          max_dly      = 0;
  int          stall_cycles = 0;
  bit          outstanding  = 0;
  int          rsp_dly      = 0;
  logic [63:0] o_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [63:0] a);
    exp_instr_t e;
    e.addr = a;
    e.word = mem_word(a);
    exp_addr.push_back(a);
    exp_instr.push_back(e);
  endtask

  // Instruction memory: at most one outstanding read, random latency,
  // and junk response pulses while a request is pending (must be ignored).
  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 1'b0;
    imem_rdata     = $urandom;
    imem_req_ready = 1'b0;
    if (rst) begin
      outstanding = 0;
    end else begin
      if (outstanding) begin
        if (rsp_dly == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rdata     = mem_word(o_addr);
          outstanding    = 0;
        end else begin
          rsp_dly--;
        end
      end
      if (imem_req_valid) begin
        imem_rsp_valid = (stall_cycles > 0) || ($urandom_range(1) == 1);
        if (stall_cycles == 0 && $urandom_range(99) < ready_pct) begin
          imem_req_ready = 1'b1;
          outstanding    = 1;
          o_addr         = imem_addr;
          rsp_dly        = $urandom_range(max_dly);
        end
      end
      if (stall_cycles > 0) stall_cycles--;
    end
  end

  // Monitor: every accepted request and every consumed instruction is
  // matched against the next entry the reference model queued.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr 0x%0h, none expected", imem_addr);
        end else begin
          check("imem_addr", imem_addr, exp_addr.pop_front());
        end
      end
      if (instr_valid && instr_ready) begin
        if (exp_instr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc 0x%0h, none expected", pc);
        end else begin
          exp_instr_t e;
          e = exp_instr.pop_front();
          check("instr_pc", pc, e.addr);
          check("instr_word", {32'h0, instr}, {32'h0, e.word});
        end
      end
    end
  end

  task automatic do_reset(input int post_stall);
    rst          = 1'b1;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    imm_branch   = '0;
    exp_addr.delete();
    exp_instr.delete();
    m_pc    = RST_PC;
    m_fault = 0;
    push_fetch(RST_PC);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_instr", {32'h0, instr}, 64'h0);
    check("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    check("rst_misalign", {63'h0, fetch_misalign}, 64'h0);
    repeat (2) @(posedge clk);
    #2;
    stall_cycles = post_stall;
    rst = 1'b0;
  endtask

  // Wait for an instruction, optionally stall decode, then accept it with the
  // given branch decision and update the reference model.
  task automatic consume(input bit taken, input logic [63:0] imm, input int hold, input int stall);
    logic [31:0] h_instr;
    logic [63:0] h_pc;
    logic [63:0] tgt;
    int          t;
    t = 0;
    while (!instr_valid) begin
      @(posedge clk);
      #2;
      t++;
      if (t > 200) begin
        $display("FAIL instr_valid_timeout: no instruction after %0d cycles", t);
        $fatal(1, "fetch stalled");
      end
    end
    check("pc_at_decode", pc, m_pc);
    h_instr = instr;
    h_pc    = pc;
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      @(posedge clk);
      #2;
      check("hold_valid", {63'h0, instr_valid}, 64'h1);
      check("hold_instr", {32'h0, instr}, {32'h0, h_instr});
      check("hold_pc", pc, h_pc);
      check("hold_no_req", {63'h0, imem_req_valid}, 64'h0);
    end
    instr_ready  = 1'b1;
    branch_taken = taken;
    imm_branch   = imm;
    stall_cycles = stall;
    if (taken) begin
      tgt = m_pc + imm;
      if (tgt[1]) m_fault = 1;
      else        m_pc    = tgt;
    end else begin
      m_pc = m_pc + 64'd4;
    end
    if (!m_fault) push_fetch(m_pc);
    @(posedge clk);
    #2;
    instr_ready  = 1'b0;
    branch_taken = $urandom_range(1);
    imm_branch   = {$urandom, $urandom};
    check("post_accept_valid", {63'h0, instr_valid}, 64'h0);
    if (m_fault) begin
      for (int i = 0; i < 5; i++) begin
        check("fault_misalign", {63'h0, fetch_misalign}, 64'h1);
        check("fault_no_req", {63'h0, imem_req_valid}, 64'h0);
        check("fault_no_instr", {63'h0, instr_valid}, 64'h0);
        check("fault_pc", pc, m_pc);
        @(posedge clk);
        #2;
      end
    end else begin
      check("next_req_valid", {63'h0, imem_req_valid}, 64'h1);
      check("next_addr", imem_addr, m_pc);
      check("no_misalign", {63'h0, fetch_misalign}, 64'h0);
      for (int i = 1; i < stall; i++) begin
        @(posedge clk);
        #2;
        check("stall_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check("stall_addr", imem_addr, m_pc);
      end
    end
  endtask

  task automatic consume_to(input logic [63:0] target);
    consume(1'b1, target - m_pc, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [63:0] imm;
    rst            = 1'b1;
    instr_ready    = 1'b0;
    branch_taken   = 1'b0;
    imm_branch     = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    @(posedge clk);
    #2;
    do_reset(0);

    // Straight-line fetch, request stall, then decode back-pressure.
    consume(1'b0, 64'h0, 0, 3);
    consume(1'b0, 64'h0, 4, 0);
    consume(1'b0, 64'h0, 0, 0);

    // Backward and forward branches.
    consume_to(64'h200);
    consume(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    consume_to(64'h200);
    consume(1'b1, 64'h1000, 1, 0);

    // Wrap-around on sequential and branch arithmetic.
    consume_to(64'hFFFF_FFFF_FFFF_FFFC);
    consume(1'b0, 64'h0, 0, 0);
    consume_to(64'h10);
    consume(1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 0, 0);
    consume(1'b0, 64'h0, 0, 0);

    // Misaligned branch target parks the fetch unit.
    consume_to(64'h300);
    consume(1'b1, 64'h6, 0, 0);

    // Reset while a read is in flight; stale responses must be ignored.
    ready_pct = 100;
    do_reset(0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) break;
    end
    @(posedge clk);
    #2;
    do_reset(4);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      check("stale_rsp_valid", {63'h0, instr_valid}, 64'h0);
      check("stale_rsp_req", {63'h0, imem_req_valid}, 64'h1);
      check("stale_rsp_addr", imem_addr, RST_PC);
    end
    consume(1'b0, 64'h0, 0, 0);

    // Random traffic.
    ready_pct = 60;
    max_dly   = 3;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(99);
      if (r < 3) begin
        imm = ({$urandom, $urandom} & ~64'h3) | 64'h2;
        consume(1'b1, imm, $urandom_range(2), $urandom_range(2));
      end else if (r < 35) begin
        imm = {$urandom, $urandom} & ~64'h3;
        consume(1'b1, imm, $urandom_range(2), $urandom_range(2));
      end else begin
        consume(1'b0, 64'h0, $urandom_range(2), $urandom_range(2));
      end
      if (m_fault) do_reset(0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
